// File: rtl/datapath_param.sv
// datapath_param
//   Bus datapath for the mini CPU. NUM_REGS general-purpose registers, HI/LO, Y, Z (ZHI/ZLO),
//   PC, MAR, MDR and InPort share one combinational bus selected by src_sel. A single-cycle ALU
//   (A = Y, B = bus) writes Z on z_in. A multi-cycle signed MUL/DIV sequencer owns Z while busy.
//
// Ports
//   clock, clear        : rising-edge clock, synchronous active-high reset
//   src_sel, imm        : bus source select; immediate value for the IMM encoding
//   reg_in, hi_in, lo_in, pc_in, y_in, mar_in : write enables, bus -> register
//   mdr_in, mdr_read, mem_data_in : MDR load from memory data (mdr_read=1) or from the bus
//   inport_strobe, inport_data    : InPort capture
//   op, z_in, alu_start : ALU opcode, single-cycle Z capture, MUL(11)/DIV(12) start
//   bus_out, mar_out, mdr_out     : bus value, memory address, memory write data
//   busy, done, div_zero          : sequencer running, one-cycle completion pulse, sticky div-by-0
//
// Build option
//   DP_R0_ZERO_EN : when defined, R0 is hardwired to zero and reg_in[0] is ignored.
//
// Sequencer states
//   state  | meaning
//   S_IDLE | Z writable by z_in; waiting for an accepted alu_start
//   S_RUN  | one shift-add / restoring-divide step per cycle, counter 0..DATA_W-1

module datapath_param #(
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 16,
  parameter int  OP_W     = 5,
  localparam int SEL_W    = $clog2(NUM_REGS + 8)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [SEL_W-1:0]    src_sel,
  input  logic [DATA_W-1:0]   imm,
  input  logic [NUM_REGS-1:0] reg_in,
  input  logic                hi_in,
  input  logic                lo_in,
  input  logic                pc_in,
  input  logic                y_in,
  input  logic                mar_in,
  input  logic                mdr_in,
  input  logic                mdr_read,
  input  logic [DATA_W-1:0]   mem_data_in,
  input  logic                inport_strobe,
  input  logic [DATA_W-1:0]   inport_data,
  input  logic [OP_W-1:0]     op,
  input  logic                z_in,
  input  logic                alu_start,
  output logic [DATA_W-1:0]   bus_out,
  output logic [DATA_W-1:0]   mar_out,
  output logic [DATA_W-1:0]   mdr_out,
  output logic                busy,
  output logic                done,
  output logic                div_zero
);

  localparam int LG = $clog2(DATA_W);

`ifdef DP_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam logic [SEL_W-1:0] SEL_HI     = SEL_W'(NUM_REGS + 0);
  localparam logic [SEL_W-1:0] SEL_LO     = SEL_W'(NUM_REGS + 1);
  localparam logic [SEL_W-1:0] SEL_ZHI    = SEL_W'(NUM_REGS + 2);
  localparam logic [SEL_W-1:0] SEL_ZLO    = SEL_W'(NUM_REGS + 3);
  localparam logic [SEL_W-1:0] SEL_PC     = SEL_W'(NUM_REGS + 4);
  localparam logic [SEL_W-1:0] SEL_MDR    = SEL_W'(NUM_REGS + 5);
  localparam logic [SEL_W-1:0] SEL_INPORT = SEL_W'(NUM_REGS + 6);
  localparam logic [SEL_W-1:0] SEL_IMM    = SEL_W'(NUM_REGS + 7);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SHRA = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ROR  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ROL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_INC  = OP_W'(13);

  localparam logic [LG-1:0] CNT_LAST = LG'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [DATA_W-1:0] r_gpr [NUM_REGS];
  logic [DATA_W-1:0] r_hi, r_lo, r_y, r_pc, r_mar, r_mdr, r_inport, r_zhi, r_zlo;

  state_t            r_state;
  logic [LG-1:0]     r_cnt;
  logic [DATA_W-1:0] r_acc_hi;   // MUL: partial product high; DIV: remainder
  logic [DATA_W-1:0] r_acc_lo;   // MUL: multiplier / product low; DIV: dividend -> quotient
  logic [DATA_W-1:0] r_opb;      // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic              r_is_div;
  logic              r_neg_q;    // sign of product or quotient
  logic              r_neg_r;    // sign of remainder (dividend sign)
  logic              r_done;
  logic              r_div_zero;

  logic [DATA_W-1:0]   w_bus;
  logic [DATA_W-1:0]   w_alu;
  logic [LG-1:0]       w_sh;
  logic [LG-1:0]       w_nsh;
  logic                w_y_neg, w_b_neg;
  logic [DATA_W-1:0]   w_y_mag, w_b_mag;
  logic                w_op_seq;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_madd;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_step_hi, w_step_lo;
  logic [2*DATA_W-1:0] w_prod, w_prod_fix;
  logic [DATA_W-1:0]   w_quo_fix, w_rem_fix;

  // Bus source mux; encodings past IMM drive zero.
  always_comb begin
    w_bus = '0;
    case (src_sel)
      SEL_HI:     w_bus = r_hi;
      SEL_LO:     w_bus = r_lo;
      SEL_ZHI:    w_bus = r_zhi;
      SEL_ZLO:    w_bus = r_zlo;
      SEL_PC:     w_bus = r_pc;
      SEL_MDR:    w_bus = r_mdr;
      SEL_INPORT: w_bus = r_inport;
      SEL_IMM:    w_bus = imm;
      default: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (src_sel == SEL_W'(i)) w_bus = r_gpr[i];
        end
      end
    endcase
  end

  // Rotates use the negated shift amount modulo DATA_W, so a zero rotate ORs A with itself.
  assign w_sh  = w_bus[LG-1:0];
  assign w_nsh = '0 - w_sh;

  always_comb begin
    w_alu = '0;
    case (op)
      OP_ADD:  w_alu = r_y + w_bus;
      OP_SUB:  w_alu = r_y - w_bus;
      OP_AND:  w_alu = r_y & w_bus;
      OP_OR:   w_alu = r_y | w_bus;
      OP_SHR:  w_alu = r_y >> w_sh;
      OP_SHRA: w_alu = $signed(r_y) >>> w_sh;
      OP_SHL:  w_alu = r_y << w_sh;
      OP_ROR:  w_alu = (r_y >> w_sh) | (r_y << w_nsh);
      OP_ROL:  w_alu = (r_y << w_sh) | (r_y >> w_nsh);
      OP_NEG:  w_alu = '0 - w_bus;
      OP_NOT:  w_alu = ~w_bus;
      OP_INC:  w_alu = w_bus + DATA_W'(1);
      default: w_alu = '0;
    endcase
  end

  assign w_y_neg  = r_y[DATA_W-1];
  assign w_b_neg  = w_bus[DATA_W-1];
  assign w_y_mag  = w_y_neg ? ('0 - r_y) : r_y;
  assign w_b_mag  = w_b_neg ? ('0 - w_bus) : w_bus;
  assign w_op_seq = (op == OP_MUL) || (op == OP_DIV);

  // One iteration of shift-add multiply or restoring divide on magnitudes.
  assign w_sum   = {1'b0, r_acc_hi} + {1'b0, r_opb};
  assign w_madd  = r_acc_lo[0] ? w_sum : {1'b0, r_acc_hi};
  assign w_shift = {r_acc_hi, r_acc_lo[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_opb};

  always_comb begin
    w_step_hi = '0;
    w_step_lo = '0;
    if (r_is_div) begin
      if (!w_diff[DATA_W]) begin
        w_step_hi = w_diff[DATA_W-1:0];
        w_step_lo = {r_acc_lo[DATA_W-2:0], 1'b1};
      end else begin
        w_step_hi = w_shift[DATA_W-1:0];
        w_step_lo = {r_acc_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_step_hi = w_madd[DATA_W:1];
      w_step_lo = {w_madd[0], r_acc_lo[DATA_W-1:1]};
    end
  end

  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_fix = r_neg_q ? ('0 - w_prod) : w_prod;
  assign w_quo_fix  = r_neg_q ? ('0 - w_step_lo) : w_step_lo;
  assign w_rem_fix  = r_neg_r ? ('0 - w_step_hi) : w_step_hi;

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_gpr[i] <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_y        <= '0;
      r_pc       <= '0;
      r_mar      <= '0;
      r_mdr      <= '0;
      r_inport   <= '0;
      r_zhi      <= '0;
      r_zlo      <= '0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opb      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;

      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_in[i] && !(R0_ZERO && i == 0)) r_gpr[i] <= w_bus;
      end
      if (hi_in)         r_hi     <= w_bus;
      if (lo_in)         r_lo     <= w_bus;
      if (pc_in)         r_pc     <= w_bus;
      if (y_in)          r_y      <= w_bus;
      if (mar_in)        r_mar    <= w_bus;
      if (mdr_in)        r_mdr    <= mdr_read ? mem_data_in : w_bus;
      if (inport_strobe) r_inport <= inport_data;

      case (r_state)
        S_IDLE: begin
          if (z_in) begin
            r_zlo <= w_alu;
            r_zhi <= '0;
          end
          if (alu_start && w_op_seq) begin
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_is_div   <= (op == OP_DIV);
            r_neg_q    <= w_y_neg ^ w_b_neg;
            r_neg_r    <= w_y_neg;
            r_acc_hi   <= '0;
            r_acc_lo   <= w_y_mag;
            r_opb      <= w_b_mag;
            // Zero divisor finishes at once and takes priority over a same-edge z_in.
            if ((op == OP_DIV) && (w_bus == '0)) begin
              r_zlo      <= '1;
              r_zhi      <= r_y;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_cnt    <= r_cnt + LG'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            if (r_is_div) begin
              r_zlo <= w_quo_fix;
              r_zhi <= w_rem_fix;
            end else begin
              r_zlo <= w_prod_fix[DATA_W-1:0];
              r_zhi <= w_prod_fix[2*DATA_W-1:DATA_W];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_out  = w_bus;
  assign mar_out  = r_mar;
  assign mdr_out  = r_mdr;
  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_datapath_param.sv
module tb_datapath_param;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = 5;

  localparam int SEL_HI = NR + 0, SEL_LO = NR + 1, SEL_ZHI = NR + 2, SEL_ZLO = NR + 3;
  localparam int SEL_PC = NR + 4, SEL_MDR = NR + 5, SEL_INPORT = NR + 6, SEL_IMM = NR + 7;

  logic          clock = 1'b0;
  logic          clear;
  logic [SW-1:0] src_sel;
  logic [DW-1:0] imm;
  logic [NR-1:0] reg_in;
  logic          hi_in, lo_in, pc_in, y_in, mar_in, mdr_in, mdr_read;
  logic [DW-1:0] mem_data_in;
  logic          inport_strobe;
  logic [DW-1:0] inport_data;
  logic [4:0]    op;
  logic          z_in, alu_start;
  logic [DW-1:0] bus_out, mar_out, mdr_out;
  logic          busy, done, div_zero;

  int n_checks = 0;
  int n_errors = 0;

  datapath_param dut (
    .clock(clock), .clear(clear), .src_sel(src_sel), .imm(imm), .reg_in(reg_in),
    .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .y_in(y_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_read(mdr_read), .mem_data_in(mem_data_in),
    .inport_strobe(inport_strobe), .inport_data(inport_data), .op(op), .z_in(z_in),
    .alu_start(alu_start), .bus_out(bus_out), .mar_out(mar_out), .mdr_out(mdr_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic read_sel(input int sel, output logic [DW-1:0] v);
    src_sel = SW'(sel);
    #1;
    v = bus_out;
  endtask

  task automatic put_imm(input logic [DW-1:0] v);
    src_sel = SW'(SEL_IMM);
    imm     = v;
  endtask

  task automatic load_y(input logic [DW-1:0] v);
    put_imm(v);
    y_in = 1'b1;
    step();
    y_in = 1'b0;
  endtask

  task automatic load_reg(input int idx, input logic [DW-1:0] v);
    put_imm(v);
    reg_in = NR'(1) << idx;
    step();
    reg_in = '0;
  endtask

  task automatic start_op(input logic [4:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    load_y(a);
    put_imm(b);
    op        = o;
    alu_start = 1'b1;
    step();
    alu_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int nb = 0;
    int n  = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      step();
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic check_z(input string tag, input logic [DW-1:0] ehi, input logic [DW-1:0] elo);
    logic [DW-1:0] v;
    read_sel(SEL_ZHI, v);
    chk({tag, "_zhi"}, 64'(v), 64'(ehi));
    read_sel(SEL_ZLO, v);
    chk({tag, "_zlo"}, 64'(v), 64'(elo));
  endtask

  typedef struct {
    logic [4:0]    o;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } alu_vec_t;

  alu_vec_t alu_vecs[12] = '{
    '{5'd2,  32'hFFFF0000, 32'h80000000},
    '{5'd3,  32'h0000FFFF, 32'h8000FFFF},
    '{5'd4,  32'h00000024, 32'h08000000},
    '{5'd5,  32'h00000024, 32'hF8000000},
    '{5'd6,  32'h00000024, 32'h00000010},
    '{5'd7,  32'h00000024, 32'h18000000},
    '{5'd8,  32'h00000024, 32'h00000018},
    '{5'd7,  32'h00000000, 32'h80000001},
    '{5'd9,  32'h00000001, 32'hFFFFFFFF},
    '{5'd10, 32'h00000000, 32'hFFFFFFFF},
    '{5'd13, 32'hFFFFFFFF, 32'h00000000},
    '{5'd14, 32'h12345678, 32'h00000000}
  };

  initial begin
    logic [DW-1:0] v;
    int dn;

    clear = 1'b1; src_sel = '0; imm = '0; reg_in = '0;
    hi_in = 0; lo_in = 0; pc_in = 0; y_in = 0; mar_in = 0; mdr_in = 0; mdr_read = 0;
    mem_data_in = '0; inport_strobe = 0; inport_data = '0; op = '0; z_in = 0; alu_start = 0;
    step();
    step();
    clear = 1'b0;

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_mar", 64'(mar_out), 64'd0);
    chk("rst_mdr", 64'(mdr_out), 64'd0);
    read_sel(3, v);
    chk("rst_r3", 64'(v), 64'd0);
    check_z("rst", 32'h0, 32'h0);

    // ADD / SUB with Y=5, bus=R1=7
    load_reg(1, 32'd7);
    load_y(32'd5);
    read_sel(1, v);
    chk("bus_r1", 64'(v), 64'd7);
    op = 5'd0; z_in = 1'b1;
    step();
    z_in = 1'b0;
    check_z("add", 32'h0, 32'h0000000C);
    src_sel = SW'(1); op = 5'd1; z_in = 1'b1;
    step();
    z_in = 1'b0;
    check_z("sub", 32'h0, 32'hFFFFFFFE);

    // remaining single-cycle ops with Y=0x80000001
    load_y(32'h80000001);
    foreach (alu_vecs[k]) begin
      put_imm(alu_vecs[k].b);
      op = alu_vecs[k].o; z_in = 1'b1;
      step();
      z_in = 1'b0;
      read_sel(SEL_ZLO, v);
      chk($sformatf("alu_op%0d_v%0d", alu_vecs[k].o, k), 64'(v), 64'(alu_vecs[k].exp));
    end

    // side registers; HI and LO written together from one bus value
    put_imm(32'h00001234); mar_in = 1'b1; step(); mar_in = 1'b0;
    chk("mar", 64'(mar_out), 64'h1234);
    mem_data_in = 32'hCAFEF00D; mdr_read = 1'b1; mdr_in = 1'b1; step(); mdr_in = 1'b0;
    chk("mdr_mem", 64'(mdr_out), 64'hCAFEF00D);
    put_imm(32'h0BADF00D); mdr_read = 1'b0; mdr_in = 1'b1; step(); mdr_in = 1'b0;
    read_sel(SEL_MDR, v);
    chk("mdr_bus", 64'(v), 64'h0BADF00D);
    inport_data = 32'h55AA55AA; inport_strobe = 1'b1; step(); inport_strobe = 1'b0;
    read_sel(SEL_INPORT, v);
    chk("inport", 64'(v), 64'h55AA55AA);
    put_imm(32'hA5A5A5A5); hi_in = 1'b1; lo_in = 1'b1; pc_in = 1'b1; step();
    hi_in = 1'b0; lo_in = 1'b0; pc_in = 1'b0;
    read_sel(SEL_HI, v); chk("hi", 64'(v), 64'hA5A5A5A5);
    read_sel(SEL_LO, v); chk("lo", 64'(v), 64'hA5A5A5A5);
    read_sel(SEL_PC, v); chk("pc", 64'(v), 64'hA5A5A5A5);
    read_sel(25, v); chk("bus_unused_sel", 64'(v), 64'd0);

    // MUL -3 * 7
    load_y(32'hFFFFFFFD);
    src_sel = SW'(1); op = 5'd11; alu_start = 1'b1;
    step();
    alu_start = 1'b0;
    wait_done("mul_m3x7", 32);
    check_z("mul_m3x7", 32'hFFFFFFFF, 32'hFFFFFFEB);
    step();
    chk("mul_done_pulse", 64'(done), 64'd0);

    // DIV
    start_op(5'd12, 32'd17, 32'hFFFFFFFB);
    wait_done("div_17_m5", 32);
    check_z("div_17_m5", 32'h00000002, 32'hFFFFFFFD);
    start_op(5'd12, 32'hFFFFFFEF, 32'd5);
    wait_done("div_m17_5", 32);
    check_z("div_m17_5", 32'hFFFFFFFE, 32'hFFFFFFFD);

    // DIV by zero completes at once; next start clears div_zero
    start_op(5'd12, 32'd9, 32'd0);
    chk("div0_done", 64'(done), 64'd1);
    chk("div0_busy", 64'(busy), 64'd0);
    chk("div0_flag", 64'(div_zero), 64'd1);
    check_z("div0", 32'd9, 32'hFFFFFFFF);
    step();
    chk("div0_done_pulse", 64'(done), 64'd0);
    chk("div0_sticky", 64'(div_zero), 64'd1);
    start_op(5'd11, 32'd9, 32'd2);
    chk("div0_cleared", 64'(div_zero), 64'd0);
    wait_done("mul_9x2", 32);
    check_z("mul_9x2", 32'h0, 32'd18);

    // most negative operand
    start_op(5'd11, 32'h80000000, 32'hFFFFFFFF);
    wait_done("mul_min_m1", 32);
    check_z("mul_min_m1", 32'h0, 32'h80000000);

    // start and z_in while busy are ignored; Z holds until the sequencer writes it
    start_op(5'd11, 32'd6, 32'd7);
    step(); step();
    put_imm(32'd0); op = 5'd12; alu_start = 1'b1; z_in = 1'b1;
    step();
    alu_start = 1'b0; z_in = 1'b0; op = 5'd11;
    chk("busy_start_ignored_flag", 64'(div_zero), 64'd0);
    check_z("busy_z_hold", 32'h0, 32'h80000000);
    wait_done("mul_6x7", 29);
    check_z("mul_6x7", 32'h0, 32'd42);

    // clear during MUL aborts with Z = 0 and no done
    start_op(5'd11, 32'hFFFFFFFD, 32'd7);
    for (int c = 0; c < 9; c++) step();
    chk("abort_busy_before", 64'(busy), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    check_z("abort", 32'h0, 32'h0);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dn++;
      step();
    end
    chk("abort_no_done", 64'(dn), 64'd0);

    // R0 behaviour depends on DP_R0_ZERO_EN
    load_reg(0, 32'hDEADBEEF);
    read_sel(0, v);
`ifdef DP_R0_ZERO_EN
    chk("r0_read", 64'(v), 64'h0);
`else
    chk("r0_read", 64'(v), 64'hDEADBEEF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
